// File: rtl/uart_dma_pkg.sv
// Shared types and default sizing for the UART-to-memory DMA engine.
package uart_dma_pkg;

   localparam int DATA_WIDTH = 8;
   localparam int ADDR_WIDTH = 8;
   localparam int LEN_WIDTH  = 5;
   localparam int TIMEOUT    = 8;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT,
      WRITE,
      DONE
   } dma_state_t;

endpackage

// File: rtl/uart_dma_ctrl.sv
// Pulls bytes from the UART one at a time and writes them to consecutive
// memory addresses; every output is registered from the next-state decode.
//
// state | meaning
// IDLE  | waiting for start
// REQ   | uart_re raised, gives the UART a fresh rising edge
// WAIT  | uart_re held, timer counts until uart_valid or timeout
// WRITE | uart_re dropped, mem_we strobes the captured byte
// DONE  | one-cycle done pulse, back to IDLE
module uart_dma_ctrl #(
   parameter int DATA_WIDTH = uart_dma_pkg::DATA_WIDTH,
   parameter int ADDR_WIDTH = uart_dma_pkg::ADDR_WIDTH,
   parameter int LEN_WIDTH  = uart_dma_pkg::LEN_WIDTH,
   parameter int TIMEOUT    = uart_dma_pkg::TIMEOUT
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] dst_addr,
   input  logic [LEN_WIDTH-1:0]  length,
   output logic                  uart_re,
   input  logic [DATA_WIDTH-1:0] uart_data,
   input  logic                  uart_valid,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [LEN_WIDTH-1:0]  byte_count
);
   import uart_dma_pkg::*;

   localparam int TW = $clog2(TIMEOUT);

   dma_state_t            state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [LEN_WIDTH-1:0]  len_q, len_d;
   logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
   logic [TW-1:0]         timer_q, timer_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [ADDR_WIDTH-1:0] maddr_q, maddr_d;
   logic                  err_q, err_d;
   logic                  re_q, we_q, busy_q, done_q;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      timer_d = timer_q;
      wdata_d = wdata_q;
      maddr_d = maddr_q;
      err_d   = err_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               cnt_d = '0;
               err_d = 1'b0;
               if (length != '0) begin
                  addr_d  = dst_addr;
                  len_d   = length;
                  state_d = REQ;
               end else begin
                  state_d = DONE;
               end
            end
         end
         REQ: begin
            timer_d = '0;
            state_d = WAIT;
         end
         WAIT: begin
            if (uart_valid) begin
               wdata_d = uart_data;
               maddr_d = addr_q;
               state_d = WRITE;
            end else if (timer_q == TW'(TIMEOUT - 1)) begin
               err_d   = 1'b1;
               state_d = DONE;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         WRITE: begin
            addr_d  = addr_q + 1'b1;
            cnt_d   = cnt_q + 1'b1;
            state_d = (cnt_d == len_q) ? DONE : REQ;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         len_q   <= '0;
         cnt_q   <= '0;
         timer_q <= '0;
         wdata_q <= '0;
         maddr_q <= '0;
         err_q   <= 1'b0;
         re_q    <= 1'b0;
         we_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         timer_q <= timer_d;
         wdata_q <= wdata_d;
         maddr_q <= maddr_d;
         err_q   <= err_d;
         // Decoding the next state keeps every strobe registered yet cycle-aligned with its state.
         re_q    <= (state_d == REQ) || (state_d == WAIT);
         we_q    <= (state_d == WRITE);
         busy_q  <= (state_d == REQ) || (state_d == WAIT) || (state_d == WRITE);
         done_q  <= (state_d == DONE);
      end
   end

   assign uart_re    = re_q;
   assign mem_we     = we_q;
   assign mem_addr   = maddr_q;
   assign mem_wdata  = wdata_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign error      = err_q;
   assign byte_count = cnt_q;

endmodule

// File: tb/tb_uart_dma_ctrl.sv
// Directed bench: behavioural UART ("Advanced Digital") and byte memory around uart_dma_ctrl.
module tb_uart_dma_ctrl;

   logic       clk;
   logic       rst;
   logic       start;
   logic [7:0] dst_addr;
   logic [4:0] length;
   logic       uart_re;
   logic [7:0] uart_data;
   logic       uart_valid;
   logic       mem_we;
   logic [7:0] mem_addr;
   logic [7:0] mem_wdata;
   logic       busy;
   logic       done;
   logic       error;
   logic [4:0] byte_count;

   uart_dma_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .dst_addr   (dst_addr),
      .length     (length),
      .uart_re    (uart_re),
      .uart_data  (uart_data),
      .uart_valid (uart_valid),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .busy       (busy),
      .done       (done),
      .error      (error),
      .byte_count (byte_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // UART model: one byte per rising edge of re, data_valid pulses for one cycle.
   logic [7:0] ubuf [16];
   logic [3:0] uptr;
   logic       u_re_prev;
   logic [7:0] u_data;
   logic       u_valid;
   logic       uart_rst;
   logic       stub;

   always @(posedge clk) begin
      if (uart_rst) begin
         uptr      <= '0;
         u_re_prev <= 1'b0;
         u_valid   <= 1'b0;
         u_data    <= '0;
      end else begin
         u_re_prev <= uart_re;
         u_valid   <= 1'b0;
         if (uart_re && !u_re_prev) begin
            u_data  <= ubuf[uptr];
            uptr    <= uptr + 1'b1;
            u_valid <= 1'b1;
         end
      end
   end

   assign uart_data  = u_data;
   assign uart_valid = stub ? 1'b0 : u_valid;

   logic [7:0] mem [256];
   int         wr_cnt;
   int         re_rises;
   logic       re_prev_tb;

   always @(posedge clk) begin
      re_prev_tb <= uart_re;
      if (uart_re && !re_prev_tb) re_rises <= re_rises + 1;
      if (mem_we) begin
         mem[mem_addr] <= mem_wdata;
         wr_cnt        <= wr_cnt + 1;
      end
   end

   int checks;
   int failures;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [7:0] a, input logic [4:0] n);
      dst_addr = a;
      length   = n;
      start    = 1'b1;
      tick();
      start    = 1'b0;
   endtask

   // Counts edges after the start edge until done is seen; busy must hold throughout.
   task automatic wait_done(input int maxc, output int edges, output logic busy_ok);
      edges   = 0;
      busy_ok = 1'b1;
      while (!done && edges < maxc) begin
         if (!busy) busy_ok = 1'b0;
         tick();
         edges++;
      end
   endtask

   task automatic pulse_uart_rst();
      uart_rst = 1'b1;
      tick();
      uart_rst = 1'b0;
   endtask

   int         edges;
   logic       busy_ok;
   int         w0;
   int         r0;
   logic [7:0] exp_str [16];

   initial begin
      checks     = 0;
      failures   = 0;
      wr_cnt     = 0;
      re_rises   = 0;
      re_prev_tb = 1'b0;
      exp_str = '{8'h41, 8'h64, 8'h76, 8'h61, 8'h6E, 8'h63, 8'h65, 8'h64,
                  8'h20, 8'h44, 8'h69, 8'h67, 8'h69, 8'h74, 8'h61, 8'h6C};
      ubuf     = exp_str;
      rst      = 1'b1;
      uart_rst = 1'b1;
      stub     = 1'b0;
      start    = 1'b0;
      dst_addr = '0;
      length   = '0;
      tick();
      tick();
      check("reset_outputs", {6'd0, uart_re, mem_we, busy, done, error, mem_addr, mem_wdata, byte_count}, 32'd0);
      rst      = 1'b0;
      uart_rst = 1'b0;
      tick();

      // 16 bytes to 0x20
      w0 = wr_cnt;
      do_start(8'h20, 5'd16);
      check("first_busy", {31'd0, busy}, 32'd1);
      wait_done(100, edges, busy_ok);
      check("full_done_edges", edges, 48);
      check("full_busy_held", {31'd0, busy_ok}, 32'd1);
      check("full_busy_at_done", {31'd0, busy}, 32'd0);
      check("full_error", {31'd0, error}, 32'd0);
      check("full_byte_count", {27'd0, byte_count}, 32'd16);
      check("full_writes", wr_cnt - w0, 16);
      for (int i = 0; i < 16; i++)
         check($sformatf("full_mem_%0h", 8'h20 + i), {24'd0, mem[8'h20 + i]}, {24'd0, exp_str[i]});
      tick();
      check("done_one_cycle", {31'd0, done}, 32'd0);

      // two back-to-back transfers sharing the UART pointer
      pulse_uart_rst();
      r0 = re_rises;
      do_start(8'h00, 5'd3);
      wait_done(100, edges, busy_ok);
      check("len3_done_edges", edges, 9);
      tick();
      do_start(8'h10, 5'd2);
      wait_done(100, edges, busy_ok);
      check("len2_done_edges", edges, 6);
      check("len2_byte_count", {27'd0, byte_count}, 32'd2);
      tick();
      check("re_rising_edges", re_rises - r0, 5);
      check("mem_00", {24'd0, mem[8'h00]}, 32'h41);
      check("mem_01", {24'd0, mem[8'h01]}, 32'h64);
      check("mem_02", {24'd0, mem[8'h02]}, 32'h76);
      check("mem_10", {24'd0, mem[8'h10]}, 32'h61);
      check("mem_11", {24'd0, mem[8'h11]}, 32'h6E);

      // zero length
      w0 = wr_cnt;
      r0 = re_rises;
      do_start(8'h50, 5'd0);
      check("len0_done_cycle1", {31'd0, done}, 32'd1);
      check("len0_busy", {31'd0, busy}, 32'd0);
      check("len0_re_we", {30'd0, uart_re, mem_we}, 32'd0);
      tick();
      check("len0_after", {29'd0, done, busy, uart_re}, 32'd0);
      tick();
      check("len0_no_write", wr_cnt - w0, 0);
      check("len0_no_re", re_rises - r0, 0);

      // address wrap
      pulse_uart_rst();
      do_start(8'hFE, 5'd3);
      wait_done(100, edges, busy_ok);
      check("wrap_done_edges", edges, 9);
      tick();
      check("wrap_mem_fe", {24'd0, mem[8'hFE]}, 32'h41);
      check("wrap_mem_ff", {24'd0, mem[8'hFF]}, 32'h64);
      check("wrap_mem_00", {24'd0, mem[8'h00]}, 32'h76);

      // silent UART: timeout
      stub = 1'b1;
      w0   = wr_cnt;
      do_start(8'h30, 5'd4);
      wait_done(40, edges, busy_ok);
      check("to_done_seen", {31'd0, done}, 32'd1);
      check("to_done_edges", edges, 9);
      check("to_error", {31'd0, error}, 32'd1);
      check("to_re_low", {31'd0, uart_re}, 32'd0);
      check("to_byte_count", {27'd0, byte_count}, 32'd0);
      check("to_no_write", wr_cnt - w0, 0);
      tick();
      tick();
      check("to_error_sticky", {30'd0, error, done}, 32'd2);
      stub = 1'b0;

      // reset in WAIT of byte 2; start while busy ignored
      pulse_uart_rst();
      w0 = wr_cnt;
      do_start(8'h40, 5'd16);
      check("new_start_clears_error", {31'd0, error}, 32'd0);
      dst_addr = 8'h80;
      length   = 5'd1;
      start    = 1'b1;
      tick();
      start    = 1'b0;
      check("busy_start_wait", {30'd0, busy, uart_re}, 32'd3);
      tick();
      check("first_we_cycle3", {15'd0, mem_we, mem_addr, mem_wdata}, {15'd0, 1'b1, 8'h40, 8'h41});
      tick();
      tick();
      check("byte2_wait", {30'd0, uart_re, mem_we}, 32'd2);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_outputs", {6'd0, uart_re, mem_we, busy, done, error, mem_addr, mem_wdata, byte_count}, 32'd0);
      tick();
      tick();
      check("midrst_idle", {29'd0, busy, uart_re, mem_we}, 32'd0);
      check("midrst_one_write", wr_cnt - w0, 1);
      check("midrst_mem_40", {24'd0, mem[8'h40]}, 32'h41);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
